// File: rtl/cmp_sched_pkg.sv
// cmp_sched_pkg: shared definitions for the CMP scheduler.
//   - CMPOp codes understood by the comparator (CMP_BEQ, CMP_BIOAL).
//   - Scheduler FSM state encoding.
//   - Result bundle and the op-based masking helper.
package cmp_sched_pkg;

  localparam int unsigned CmpOpW = 2;

  // CMPOp codes; every other code is reported back as an error.
  localparam logic [CmpOpW-1:0] CMP_BEQ   = 2'b00;
  localparam logic [CmpOpW-1:0] CMP_BIOAL = 2'b01;

  typedef enum logic [1:0] {
    SchedIdle = 2'b00,
    SchedEval = 2'b01,
    SchedResp = 2'b10
  } sched_state_e;

  typedef struct packed {
    logic zero;
    logic ovf;
    logic err;
  } cmp_res_t;

  // The comparator drives both flags for every op, so a flag is only meaningful
  // when the latched op actually asked for it.
  function automatic cmp_res_t mask_result(logic [CmpOpW-1:0] op, logic zero, logic ovf);
    cmp_res_t res;
    res.zero = (op == CMP_BEQ) & zero;
    res.ovf  = (op == CMP_BIOAL) & ovf;
    res.err  = (op != CMP_BEQ) && (op != CMP_BIOAL);
    return res;
  endfunction

endpackage

// File: rtl/cmp_sched_cmp.sv
// cmp_sched_cmp: the shared comparator datapath.
//   a, b      in  DW  operands
//   zero      out 1   a == b
//   overflow  out 1   signed overflow of a + b
// Purely combinational; both flags are produced regardless of the requested op.
module cmp_sched_cmp #(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          zero,
  output logic          overflow
);

  logic [DW:0] sum;

  // Sign-extend both operands by one bit; the top two sum bits differ on overflow.
  always_comb begin
    sum      = {a[DW-1], a} + {b[DW-1], b};
    zero     = (a == b);
    overflow = sum[DW] ^ sum[DW-1];
  end

endmodule

// File: rtl/cmp_sched.sv
// cmp_sched: round-robin scheduler sharing one comparator between two requesters.
//   clk, reset            clock and synchronous active-high reset
//   req_valid/req_ready   per-port request handshake (bit i = port i)
//   req_a0/req_b0/req_op0 port 0 (branch resolver) operands and CMPOp
//   req_a1/req_b1/req_op1 port 1 (add-overflow checker) operands and CMPOp
//   rsp_valid/rsp_ready   per-port response handshake; only the owner sees valid
//   rsp_zero/ovf/err      registered result, held until the owner accepts it
// One operation in flight: IDLE (grant) -> EVAL (compute) -> RESP (hold) -> IDLE.
module cmp_sched
  import cmp_sched_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter int unsigned OPW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [DW-1:0]  req_a0,
  input  logic [DW-1:0]  req_b0,
  input  logic [OPW-1:0] req_op0,
  input  logic [DW-1:0]  req_a1,
  input  logic [DW-1:0]  req_b1,
  input  logic [OPW-1:0] req_op1,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic           rsp_zero,
  output logic           rsp_ovf,
  output logic           rsp_err
);

  sched_state_e   state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           owner_q, owner_d;
  logic [DW-1:0]  a_q, a_d;
  logic [DW-1:0]  b_q, b_d;
  logic [OPW-1:0] op_q, op_d;
  cmp_res_t       res_q, res_d;

  logic [1:0]     grant;
  logic           handshake;
  logic           cmp_zero;
  logic           cmp_ovf;

  cmp_sched_cmp #(
    .DW(DW)
  ) u_cmp (
    .a        (a_q),
    .b        (b_q),
    .zero     (cmp_zero),
    .overflow (cmp_ovf)
  );

  // Arbiter: a lone requester wins; on a tie the port that did not win last time wins.
  always_comb begin
    grant = 2'b00;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Gated by reset so nothing is accepted in the reset cycle.
  assign req_ready = ((state_q == SchedIdle) && !reset) ? grant : 2'b00;
  assign handshake = |(req_valid & req_ready);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    res_d        = res_q;
    unique case (state_q)
      SchedIdle: begin
        if (handshake) begin
          owner_d      = req_ready[1];
          last_grant_d = req_ready[1];
          a_d          = req_ready[1] ? req_a1  : req_a0;
          b_d          = req_ready[1] ? req_b1  : req_b0;
          op_d         = req_ready[1] ? req_op1 : req_op0;
          state_d      = SchedEval;
        end
      end
      SchedEval: begin
        res_d   = mask_result(CmpOpW'(op_q), cmp_zero, cmp_ovf);
        state_d = SchedResp;
      end
      SchedResp: begin
        // Only the owner's ready bit releases the result.
        if (rsp_ready[owner_q]) begin
          state_d = SchedIdle;
        end
      end
      default: state_d = SchedIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SchedIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      res_q        <= res_d;
    end
  end

  assign rsp_valid = (state_q == SchedResp) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_zero  = res_q.zero;
  assign rsp_ovf   = res_q.ovf;
  assign rsp_err   = res_q.err;

endmodule

// File: tb/tb_cmp_sched.sv
module tb_cmp_sched;
  import cmp_sched_pkg::*;

  localparam logic [1:0] OP_BAD = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  req_op0, req_op1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic        rsp_zero, rsp_ovf, rsp_err;

  typedef struct packed {
    logic zero;
    logic ovf;
    logic err;
  } exp_t;

  exp_t exp_q[$];
  exp_t held;
  int   vectors     = 0;
  int   miscompares = 0;
  int   lg          = 1;  // model of last_grant

  always #5 clk = ~clk;

  cmp_sched #(
    .DW  (32),
    .OPW (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_op0   (req_op0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_op1   (req_op1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_zero  (rsp_zero),
    .rsp_ovf   (rsp_ovf),
    .rsp_err   (rsp_err)
  );

  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    exp_t        e;
    logic [32:0] s;
    s      = {a[31], a} + {b[31], b};
    e.zero = (op == CMP_BEQ) && (a == b);
    e.ovf  = (op == CMP_BIOAL) && (s[32] != s[31]);
    e.err  = !((op == CMP_BEQ) || (op == CMP_BIOAL));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_port(input int p);
    if (p == 0) exp_q.push_back(model(req_a0, req_b0, req_op0));
    else        exp_q.push_back(model(req_a1, req_b1, req_op1));
  endtask

  task automatic check_rsp(input string tag, input int p);
    exp_t e;
    chk({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 32'(1 << p));
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      held = e;
      chk({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, e.zero});
      chk({tag, "_ovf"},  {31'd0, rsp_ovf},  {31'd0, e.ovf});
      chk({tag, "_err"},  {31'd0, rsp_err},  {31'd0, e.err});
    end
  endtask

  // Single-requester operation; checks grant, 2-cycle latency and routing.
  task automatic do_op(input string tag, input int p, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] op);
    if (p == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
    else        begin req_a1 = a; req_b1 = b; req_op1 = op; end
    req_valid = 2'(1 << p);
    rsp_ready = 2'b00;
    #1;
    chk({tag, "_grant"}, {30'd0, req_ready}, 32'(1 << p));
    push_port(p);
    lg = p;
    tick();
    req_valid = 2'b00;
    chk({tag, "_eval_ready"}, {30'd0, req_ready}, 32'd0);
    chk({tag, "_eval_rv"}, {30'd0, rsp_valid}, 32'd0);
    tick();
    check_rsp(tag, p);
    rsp_ready = 2'(1 << p);
    tick();
    rsp_ready = 2'b00;
    chk({tag, "_idle_rv"}, {30'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int g;
    reset     = 1'b1;
    req_valid = 2'b11;  // must not be accepted while in reset
    rsp_ready = 2'b00;
    req_a0 = '0; req_b0 = '0; req_op0 = CMP_BEQ;
    req_a1 = '0; req_b1 = '0; req_op1 = CMP_BEQ;
    tick();
    tick();
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_flags", {29'd0, rsp_zero, rsp_ovf, rsp_err}, 32'd0);
    req_valid = 2'b00;
    reset     = 1'b0;
    tick();

    // 1: port 0 BEQ equal operands
    do_op("t1_beq", 0, 32'h1234, 32'h1234, CMP_BEQ);
    do_op("t1_beq_ne", 0, 32'h1234, 32'h1235, CMP_BEQ);

    // 2: port 1 overflow checks
    do_op("t2_ovf", 1, 32'h7FFF_FFFF, 32'h0000_0001, CMP_BIOAL);
    do_op("t2_noovf", 1, 32'hFFFF_FFFF, 32'h0000_0001, CMP_BIOAL);
    do_op("t2_negovf", 1, 32'h8000_0000, 32'hFFFF_FFFF, CMP_BIOAL);

    // 3: both valid continuously; grants must alternate
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      req_a0 = 32'(i); req_b0 = 32'(i); req_op0 = CMP_BEQ;
      req_a1 = 32'h7FFF_FFF0; req_b1 = 32'(16 + i); req_op1 = CMP_BIOAL;
      #1;
      g = (lg == 1) ? 0 : 1;
      chk("t3_order", 32'(g), 32'(i % 2));
      chk("t3_grant", {30'd0, req_ready}, 32'(1 << g));
      push_port(g);
      lg = g;
      tick();
      chk("t3_eval_ready", {30'd0, req_ready}, 32'd0);
      tick();
      check_rsp("t3", g);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;

    // 4: owner stalls the response while port 1 waits
    req_valid = 2'b11;
    req_a0 = 32'hCAFE; req_b0 = 32'hCAFE; req_op0 = CMP_BEQ;
    req_a1 = 32'h7FFF_FFFF; req_b1 = 32'h7FFF_FFFF; req_op1 = CMP_BIOAL;
    #1;
    chk("t4_grant0", {30'd0, req_ready}, 32'(lg == 1 ? 1 : 2));
    push_port(0);
    lg = 0;
    tick();
    req_valid = 2'b10;
    chk("t4_eval_ready", {30'd0, req_ready}, 32'd0);
    tick();
    check_rsp("t4", 0);
    rsp_ready = 2'b10;  // non-owner ready must be ignored
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_rv", {30'd0, rsp_valid}, 32'd1);
      chk("t4_hold_flags", {29'd0, rsp_zero, rsp_ovf, rsp_err},
          {29'd0, held.zero, held.ovf, held.err});
      chk("t4_hold_ready", {30'd0, req_ready}, 32'd0);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    chk("t4_release_rv", {30'd0, rsp_valid}, 32'd0);
    chk("t4_grant1", {30'd0, req_ready}, 32'd2);
    push_port(1);
    lg = 1;
    tick();
    req_valid = 2'b00;
    tick();
    check_rsp("t4_p1", 1);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;

    // 5: unknown op, then reset during EVAL
    do_op("t5_bad", 0, 32'h5, 32'h5, OP_BAD);
    do_op("t5_bad1", 1, 32'h7FFF_FFFF, 32'h1, OP_BAD);
    req_a0 = 32'h9; req_b0 = 32'h9; req_op0 = CMP_BEQ;
    req_valid = 2'b01;
    #1;
    chk("t5_rst_grant", {30'd0, req_ready}, 32'd1);
    lg = 0;
    tick();
    req_valid = 2'b00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lg = 1;
    chk("t5_rst_rv", {30'd0, rsp_valid}, 32'd0);
    chk("t5_rst_flags", {29'd0, rsp_zero, rsp_ovf, rsp_err}, 32'd0);
    tick();
    chk("t5_rst_rv2", {30'd0, rsp_valid}, 32'd0);
    tick();
    chk("t5_rst_rv3", {30'd0, rsp_valid}, 32'd0);
    req_valid = 2'b11;
    req_a1 = 32'h1; req_b1 = 32'h2; req_op1 = CMP_BEQ;
    #1;
    chk("t5_tie_after_rst", {30'd0, req_ready}, 32'd1);
    push_port(0);
    lg = 0;
    tick();
    req_valid = 2'b00;
    tick();
    check_rsp("t5_after", 0);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
